clock_period_meter: RTL and testbench

- Receive-side counterpart to the clock divider/counter block: takes a slow periodic signal and measures its period in `clk` cycles.
- The input is typically a divided clock or a counter bit.
- Synchronizes the input, detects rising edges, counts cycles between consecutive edges, and reports each period with a one-cycle valid strobe.
- Also flags lock (stable period) and overflow (input stalled); used as a self-check monitor on clock-divider outputs.

---
 rtl/clock_period_meter.sv | 122 ++++++++++++
 tb/tb_clock_period_meter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Measures the period of a slow, possibly asynchronous signal in clk cycles, reporting each
// period with a one-cycle strobe plus lock (stable period) and sticky overflow (stalled input).
module clock_period_meter #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 overflow
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [MatchW-1:0] LockCnt = MatchW'(LOCK_COUNT);
  localparam logic [MatchW-1:0] MatchOne = MatchW'(1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArm     = 2'd1;
  localparam logic [1:0] StMeasure = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sig_dly_q, sig_dly_d;
  logic                   sig_s, rise;
  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic [MatchW-1:0]      match_q, match_d;

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_dly_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    sig_dly_d = sig_s;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    match_d   = match_q;

    if (!enable) begin
      // Disabling discards any in-flight measurement but keeps the last period.
      state_d = StIdle;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      match_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StArm;
        end
        StArm: begin
          if (rise) begin
            state_d = StMeasure;
            cnt_d   = CntOne;
            match_d = '0;
          end
        end
        StMeasure: begin
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CntOne;
            // match_q == 0 marks the first report since arming.
            if (match_q == '0 || cnt_q != period_q) begin
              match_d = MatchOne;
            end else if (match_q < LockCnt) begin
              match_d = match_q + MatchOne;
            end
          end else if (cnt_q == CntMax) begin
            ovf_d   = 1'b1;
            match_d = '0;
            cnt_d   = '0;
            state_d = StArm;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      sig_dly_q <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      match_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      sig_dly_q <= sig_dly_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      match_q   <= match_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = ovf_q;
  assign locked       = (match_q >= LockCnt);

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: edges driven on sig_in push expected reports into a scoreboard
// that is popped on every period_valid; status outputs are also checked at key points.
module tb_clock_period_meter;

  localparam int unsigned CntW    = 4;
  localparam int          CntMaxI = 15;
  localparam int          LockN   = 4;

  typedef struct packed {
    logic [CntW-1:0] per;
    logic            lk;
    logic            ov;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            enable = 1'b0;
  logic            sig_in = 1'b0;
  logic [CntW-1:0] period;
  logic            period_valid;
  logic            locked;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state (spec-level view of the driven waveform).
  int last_cyc = 0;
  int last_per = 0;
  int m = 0;
  bit armed = 1'b0;
  bit exp_ovf = 1'b0;

  clock_period_meter #(
    .CNT_WIDTH  (CntW),
    .SYNC_STAGES(2),
    .LOCK_COUNT (LockN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sig_in      (sig_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    armed   = 1'b0;
    m       = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int   diff;
    exp_t e;
    if (!enable) return;
    diff     = cyc - last_cyc;
    last_cyc = cyc;
    if (!armed) begin
      armed = 1'b1;
      m     = 0;
    end else if (diff > CntMaxI) begin
      // Stall overflowed the counter; this edge re-arms and is not reported.
      exp_ovf = 1'b1;
      m       = 0;
    end else begin
      if (m == 0 || diff != last_per) m = 1;
      else if (m < LockN) m = m + 1;
      last_per = diff;
      e.per = CntW'(diff);
      e.lk  = (m >= LockN);
      e.ov  = exp_ovf;
      sb.push_back(e);
    end
  endtask

  task automatic train(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sig_in = 1'b1;
      model_edge();
      repeat (per / 2) @(negedge clk);
      sig_in = 1'b0;
      repeat (per - per / 2 - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check_eq("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && period_valid) begin
      if (sb.size() == 0) begin
        check_eq("valid_without_expect", int'(period_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_period", int'(period), int'(mon_e.per));
        check_eq("sb_locked", int'(locked), int'(mon_e.lk));
        check_eq("sb_overflow", int'(overflow), int'(mon_e.ov));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    idle(2);
    check_eq("rst_period", int'(period), 0);
    check_eq("rst_valid", int'(period_valid), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    reset_n = 1'b1;

    // Toggle-every-cycle input: period 2, lock on 4th report.
    @(negedge clk);
    enable = 1'b1;
    model_reset();
    train(2, 6);
    drain();
    check_eq("s1_locked", int'(locked), 1);
    check_eq("s1_period", int'(period), 2);

    // Counter bit 2 style input: period 8.
    train(8, 6);
    drain();
    check_eq("s2_locked", int'(locked), 1);
    check_eq("s2_overflow", int'(overflow), 0);
    check_eq("s2_period", int'(period), 8);

    // Stall the input long enough to saturate the counter.
    idle(14);
    check_eq("s3_overflow", int'(overflow), 1);
    check_eq("s3_locked", int'(locked), 0);
    train(8, 6);
    drain();
    check_eq("s3_relock", int'(locked), 1);
    check_eq("s3_ovf_sticky", int'(overflow), 1);

    // Period change 8 -> 4 drops lock, then relocks.
    train(4, 6);
    drain();
    check_eq("s4_locked", int'(locked), 1);
    check_eq("s4_period", int'(period), 4);

    // Disable mid-period.
    idle(1);
    check_eq("s5_pre_locked", int'(locked), 1);
    check_eq("s5_pre_overflow", int'(overflow), 1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("s5_locked", int'(locked), 0);
    check_eq("s5_overflow", int'(overflow), 0);
    check_eq("s5_valid", int'(period_valid), 0);
    check_eq("s5_period_hold", int'(period), last_per);
    model_reset();
    train(4, 3);
    idle(4);
    enable = 1'b1;
    train(8, 6);
    drain();
    check_eq("s5_relock", int'(locked), 1);
    check_eq("s5_period", int'(period), 8);
    check_eq("s5_overflow_end", int'(overflow), 0);

    // Asynchronous reset between clock edges.
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("s6_period", int'(period), 0);
    check_eq("s6_valid", int'(period_valid), 0);
    check_eq("s6_locked", int'(locked), 0);
    check_eq("s6_overflow", int'(overflow), 0);
    @(negedge clk);
    reset_n  = 1'b1;
    model_reset();
    last_per = 0;
    train(2, 6);
    drain();
    check_eq("s6_relock", int'(locked), 1);
    check_eq("s6_period_end", int'(period), 2);
    check_eq("s6_overflow_end", int'(overflow), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
